// File: rtl/dbg_ctrl.sv
// dbg_ctrl: host-to-core debug control block.
//
// Takes debug commands from the simulator-side host over a valid/ready
// command channel and returns one response per command over a valid/ready
// response channel. The supported commands are halt, resume, single-step,
// status query, and GPR/CSR read/write. Only one command is in flight at a
// time.
//
// Ports:
//   clk, reset                   clock and asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op/cmd_addr/cmd_data     opcode, register address and write data
//   rsp_valid/rsp_ready          response handshake
//   rsp_data/rsp_err             read data or status word, error flag
//   halt_req                     asks the core to stop at an instruction boundary
//   halted, done, brk            core state, retire pulse, ebreak pulse
//   gpr_ren/gpr_raddr/gpr_rdata  GPR debug read port (data one cycle after ren)
//   csr_ren/csr_raddr/csr_rdata  CSR debug read port (data one cycle after ren)
//   gpr_wen/gpr_waddr/gpr_wdata  GPR debug write port
//   csr_wen/csr_waddr/csr_wdata  CSR debug write port
module dbg_ctrl #(
  parameter int NR_GPR       = 16,
  parameter int HALT_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        halt_req,
  input  logic        halted,
  input  logic        done,
  input  logic        brk,
  output logic        gpr_ren,
  output logic        csr_ren,
  output logic [4:0]  gpr_raddr,
  output logic [11:0] csr_raddr,
  input  logic [31:0] gpr_rdata,
  input  logic [31:0] csr_rdata,
  output logic        gpr_wen,
  output logic        csr_wen,
  output logic [4:0]  gpr_waddr,
  output logic [11:0] csr_waddr,
  output logic [31:0] gpr_wdata,
  output logic [31:0] csr_wdata
);

  localparam logic [2:0] OP_STATUS = 3'd0;
  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_RESUME = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_RD_GPR = 3'd4;
  localparam logic [2:0] OP_WR_GPR = 3'd5;
  localparam logic [2:0] OP_RD_CSR = 3'd6;
  localparam logic [2:0] OP_WR_CSR = 3'd7;

  localparam int              CNT_W    = (HALT_TIMEOUT > 2) ? $clog2(HALT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_HALT,
    ST_STEP_RUN,
    ST_STEP_HALT,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             halt_req_q, halt_req_d;
  logic             brk_flag_q, brk_flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             acc_first_q, acc_first_d;
  logic             gpr_ren_q, gpr_ren_d;
  logic             csr_ren_q, csr_ren_d;
  logic             gpr_wen_q, gpr_wen_d;
  logic             csr_wen_q, csr_wen_d;
  logic [4:0]       gpr_raddr_q, gpr_raddr_d;
  logic [11:0]      csr_raddr_q, csr_raddr_d;
  logic [4:0]       gpr_waddr_q, gpr_waddr_d;
  logic [11:0]      csr_waddr_q, csr_waddr_d;
  logic [31:0]      gpr_wdata_q, gpr_wdata_d;
  logic [31:0]      csr_wdata_q, csr_wdata_d;

  logic cmd_is_gpr;
  logic access_ok;
  logic op_is_read;
  logic timed_out;

  // Register accesses are only legal on a halted core; GPR addresses are
  // range-checked on the full 12-bit address, not just the low five bits.
  assign cmd_is_gpr = (cmd_op == OP_RD_GPR) || (cmd_op == OP_WR_GPR);
  assign access_ok  = halted && (!cmd_is_gpr || ({20'b0, cmd_addr} < NR_GPR));
  assign op_is_read = (op_q == OP_RD_GPR) || (op_q == OP_RD_CSR);
  assign timed_out  = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    halt_req_d  = halt_req_q;
    brk_flag_d  = brk_flag_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    acc_first_d = 1'b0;
    gpr_ren_d   = 1'b0;
    csr_ren_d   = 1'b0;
    gpr_wen_d   = 1'b0;
    csr_wen_d   = 1'b0;
    gpr_raddr_d = gpr_raddr_q;
    csr_raddr_d = csr_raddr_q;
    gpr_waddr_d = gpr_waddr_q;
    csr_waddr_d = csr_waddr_q;
    gpr_wdata_d = gpr_wdata_q;
    csr_wdata_d = csr_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          rsp_data_d = 32'h0;
          rsp_err_d  = 1'b0;
          case (cmd_op)
            OP_STATUS: begin
              rsp_data_d = {30'b0, brk_flag_q, halted};
              state_d    = ST_RESP;
            end
            OP_HALT: begin
              halt_req_d = 1'b1;
              cnt_d      = '0;
              state_d    = ST_WAIT_HALT;
            end
            OP_RESUME: begin
              halt_req_d = 1'b0;
              brk_flag_d = 1'b0;
              state_d    = ST_RESP;
            end
            OP_STEP: begin
              if (!halted) begin
                rsp_err_d = 1'b1;
                state_d   = ST_RESP;
              end else begin
                brk_flag_d = 1'b0;
                halt_req_d = 1'b0;
                cnt_d      = '0;
                state_d    = ST_STEP_RUN;
              end
            end
            default: begin
              if (!access_ok) begin
                rsp_err_d = 1'b1;
                state_d   = ST_RESP;
              end else begin
                acc_first_d = 1'b1;
                state_d     = ST_ACCESS;
                gpr_raddr_d = cmd_addr[4:0];
                csr_raddr_d = cmd_addr;
                gpr_waddr_d = cmd_addr[4:0];
                csr_waddr_d = cmd_addr;
                gpr_wdata_d = cmd_data;
                csr_wdata_d = cmd_data;
                gpr_ren_d   = (cmd_op == OP_RD_GPR);
                csr_ren_d   = (cmd_op == OP_RD_CSR);
                // x0 is hardwired, so the write is acknowledged but not issued.
                gpr_wen_d   = (cmd_op == OP_WR_GPR) && (cmd_addr[4:0] != 5'd0);
                csr_wen_d   = (cmd_op == OP_WR_CSR);
              end
            end
          endcase
        end
      end

      ST_WAIT_HALT: begin
        if (halted) begin
          state_d = ST_RESP;
        end else if (timed_out) begin
          rsp_err_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // The timeout budget is shared by both step phases.
      ST_STEP_RUN: begin
        if (timed_out) begin
          halt_req_d = 1'b1;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (done) begin
            halt_req_d = 1'b1;
            state_d    = ST_STEP_HALT;
          end
        end
      end

      ST_STEP_HALT: begin
        if (halted) begin
          state_d = ST_RESP;
        end else if (timed_out) begin
          halt_req_d = 1'b1;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Writes finish after their single wen cycle. Reads spend one cycle
      // with ren high, then capture rdata on the following cycle.
      ST_ACCESS: begin
        if (!op_is_read) begin
          state_d = ST_RESP;
        end else if (!acc_first_q) begin
          rsp_data_d = (op_q == OP_RD_GPR) ? gpr_rdata : csr_rdata;
          state_d    = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An ebreak always auto-halts the core and wins over a RESUME or STEP
    // accepted in the same cycle.
    if (brk) begin
      brk_flag_d = 1'b1;
      halt_req_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_STATUS;
      halt_req_q  <= 1'b0;
      brk_flag_q  <= 1'b0;
      cnt_q       <= '0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
      acc_first_q <= 1'b0;
      gpr_ren_q   <= 1'b0;
      csr_ren_q   <= 1'b0;
      gpr_wen_q   <= 1'b0;
      csr_wen_q   <= 1'b0;
      gpr_raddr_q <= 5'd0;
      csr_raddr_q <= 12'd0;
      gpr_waddr_q <= 5'd0;
      csr_waddr_q <= 12'd0;
      gpr_wdata_q <= 32'h0;
      csr_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      halt_req_q  <= halt_req_d;
      brk_flag_q  <= brk_flag_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      acc_first_q <= acc_first_d;
      gpr_ren_q   <= gpr_ren_d;
      csr_ren_q   <= csr_ren_d;
      gpr_wen_q   <= gpr_wen_d;
      csr_wen_q   <= csr_wen_d;
      gpr_raddr_q <= gpr_raddr_d;
      csr_raddr_q <= csr_raddr_d;
      gpr_waddr_q <= gpr_waddr_d;
      csr_waddr_q <= csr_waddr_d;
      gpr_wdata_q <= gpr_wdata_d;
      csr_wdata_q <= csr_wdata_d;
    end
  end

  // During a step, halt_req must rise in the same cycle as the retire pulse
  // so that exactly one instruction gets through, hence the combinational term.
  assign halt_req  = halt_req_q || ((state_q == ST_STEP_RUN) && done);
  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign gpr_ren   = gpr_ren_q;
  assign csr_ren   = csr_ren_q;
  assign gpr_wen   = gpr_wen_q;
  assign csr_wen   = csr_wen_q;
  assign gpr_raddr = gpr_raddr_q;
  assign csr_raddr = csr_raddr_q;
  assign gpr_waddr = gpr_waddr_q;
  assign csr_waddr = csr_waddr_q;
  assign gpr_wdata = gpr_wdata_q;
  assign csr_wdata = csr_wdata_q;

endmodule

// File: tb/tb_dbg_ctrl.sv
// tb_dbg_ctrl: directed self-checking bench for dbg_ctrl.
// The bench drives the host and core sides of the block. A small register
// file model answers debug reads one cycle after ren.
module tb_dbg_ctrl;

  localparam logic [2:0] OP_STATUS = 3'd0;
  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_RESUME = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_RD_GPR = 3'd4;
  localparam logic [2:0] OP_WR_GPR = 3'd5;
  localparam logic [2:0] OP_RD_CSR = 3'd6;
  localparam logic [2:0] OP_WR_CSR = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        halt_req, halted, done, brk;
  logic        gpr_ren, csr_ren, gpr_wen, csr_wen;
  logic [4:0]  gpr_raddr, gpr_waddr;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] gpr_rdata = 32'h0;
  logic [31:0] csr_rdata = 32'h0;
  logic [31:0] gpr_wdata, csr_wdata;

  int checkCount = 0;
  int failCount  = 0;
  int gprWenCount = 0;
  int gprRenCount = 0;
  int cyc;
  int base;

  logic [31:0] gprModel [0:31];
  logic [31:0] csrModel [0:15];

  dbg_ctrl #(.NR_GPR(16), .HALT_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .halt_req(halt_req), .halted(halted), .done(done), .brk(brk),
    .gpr_ren(gpr_ren), .csr_ren(csr_ren), .gpr_raddr(gpr_raddr), .csr_raddr(csr_raddr),
    .gpr_rdata(gpr_rdata), .csr_rdata(csr_rdata),
    .gpr_wen(gpr_wen), .csr_wen(csr_wen), .gpr_waddr(gpr_waddr), .csr_waddr(csr_waddr),
    .gpr_wdata(gpr_wdata), .csr_wdata(csr_wdata)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Core register file model: writes land on the wen edge, read data is
  // presented for exactly the cycle after ren and is zero otherwise.
  always @(posedge clk) begin
    if (gpr_wen) begin
      gprModel[gpr_waddr] <= gpr_wdata;
      gprWenCount <= gprWenCount + 1;
    end
    if (csr_wen) csrModel[csr_waddr[3:0]] <= csr_wdata;
    if (gpr_ren) gprRenCount <= gprRenCount + 1;
    gpr_rdata <= gpr_ren ? gprModel[gpr_raddr] : 32'h0;
    csr_rdata <= csr_ren ? csrModel[csr_raddr[3:0]] : 32'h0;
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=stall exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command for a single cycle; returns just after the accept edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] data);
    checkOutput("cmd_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitResp(input int maxCycles, output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < maxCycles) begin
      tick();
      cycles++;
    end
    checkOutput("rsp_wait_bound", rsp_valid, 1);
  endtask

  task automatic finishResp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rsp_released", rsp_valid, 0);
    checkOutput("back_to_idle", cmd_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gprModel[i] = 32'h0;
    for (int i = 0; i < 16; i++) csrModel[i] = 32'h0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 12'd0; cmd_data = 32'd0;
    rsp_ready = 1'b0; halted = 1'b0; done = 1'b0; brk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_halt_req", halt_req, 0);
    checkOutput("rst_ren_wen", {gpr_ren, csr_ren, gpr_wen, csr_wen}, 0);
    reset = 1'b1;
    tick();

    // STATUS on a running core.
    applyStimulus(OP_STATUS, 12'd0, 32'd0);
    checkOutput("status_valid", rsp_valid, 1);
    checkOutput("status_data", rsp_data, 32'h0);
    checkOutput("status_err", rsp_err, 0);
    tick();
    checkOutput("status_busy", cmd_ready, 0);
    checkOutput("status_hold", rsp_valid, 1);
    finishResp();

    // HALT with halted rising five cycles after accept.
    applyStimulus(OP_HALT, 12'd0, 32'd0);
    checkOutput("halt_req_on", halt_req, 1);
    repeat (4) tick();
    checkOutput("halt_pending", rsp_valid, 0);
    halted = 1'b1;
    waitResp(20, cyc);
    checkOutput("halt_latency", cyc, 1);
    checkOutput("halt_err", rsp_err, 0);
    finishResp();

    // RESUME drops halt_req without waiting for halted.
    applyStimulus(OP_RESUME, 12'd0, 32'd0);
    checkOutput("resume_halt_req", halt_req, 0);
    checkOutput("resume_valid", rsp_valid, 1);
    finishResp();
    halted = 1'b0;

    // HALT timeout with halted stuck low.
    applyStimulus(OP_HALT, 12'd0, 32'd0);
    waitResp(40, cyc);
    checkOutput("halt_timeout_latency", cyc, 16);
    checkOutput("halt_timeout_err", rsp_err, 1);
    checkOutput("halt_timeout_req", halt_req, 1);
    finishResp();
    halted = 1'b1;

    // GPR write to x3.
    base = gprWenCount;
    applyStimulus(OP_WR_GPR, 12'd3, 32'hDEADBEEF);
    checkOutput("wr_gpr_wen", gpr_wen, 1);
    checkOutput("wr_gpr_waddr", gpr_waddr, 3);
    checkOutput("wr_gpr_wdata", gpr_wdata, 32'hDEADBEEF);
    tick();
    checkOutput("wr_gpr_wen_drop", gpr_wen, 0);
    checkOutput("wr_gpr_valid", rsp_valid, 1);
    checkOutput("wr_gpr_err", rsp_err, 0);
    checkOutput("wr_gpr_pulses", gprWenCount - base, 1);
    finishResp();

    // GPR read of x3: response two cycles after accept.
    applyStimulus(OP_RD_GPR, 12'd3, 32'd0);
    checkOutput("rd_gpr_ren", gpr_ren, 1);
    checkOutput("rd_gpr_raddr", gpr_raddr, 3);
    checkOutput("rd_gpr_early0", rsp_valid, 0);
    tick();
    checkOutput("rd_gpr_ren_drop", gpr_ren, 0);
    checkOutput("rd_gpr_early1", rsp_valid, 0);
    tick();
    checkOutput("rd_gpr_valid", rsp_valid, 1);
    checkOutput("rd_gpr_data", rsp_data, 32'hDEADBEEF);
    checkOutput("rd_gpr_err", rsp_err, 0);
    finishResp();

    // Out-of-range GPR read: error, zero data, no ren.
    base = gprRenCount;
    applyStimulus(OP_RD_GPR, 12'd16, 32'd0);
    checkOutput("rd_gpr16_valid", rsp_valid, 1);
    checkOutput("rd_gpr16_err", rsp_err, 1);
    checkOutput("rd_gpr16_data", rsp_data, 32'h0);
    finishResp();
    checkOutput("rd_gpr16_no_ren", gprRenCount - base, 0);

    // Write to x0 is acknowledged but not issued.
    base = gprWenCount;
    applyStimulus(OP_WR_GPR, 12'd0, 32'h55);
    checkOutput("wr_x0_wen", gpr_wen, 0);
    tick();
    checkOutput("wr_x0_err", {rsp_valid, rsp_err}, 2'b10);
    finishResp();
    checkOutput("wr_x0_pulses", gprWenCount - base, 0);

    // CSR write then read back.
    applyStimulus(OP_WR_CSR, 12'h341, 32'h12345678);
    checkOutput("wr_csr_wen", csr_wen, 1);
    checkOutput("wr_csr_waddr", csr_waddr, 32'h341);
    tick();
    finishResp();
    applyStimulus(OP_RD_CSR, 12'h341, 32'd0);
    checkOutput("rd_csr_ren", csr_ren, 1);
    tick();
    tick();
    checkOutput("rd_csr_data", rsp_data, 32'h12345678);
    finishResp();

    // Single step from halted.
    applyStimulus(OP_STEP, 12'd0, 32'd0);
    checkOutput("step_release", halt_req, 0);
    halted = 1'b0;
    tick();
    checkOutput("step_running", {rsp_valid, halt_req}, 2'b00);
    done = 1'b1;
    #1;
    checkOutput("step_done_same_cycle", halt_req, 1);
    tick();
    done = 1'b0;
    checkOutput("step_halt_req_held", halt_req, 1);
    tick();
    checkOutput("step_wait_halted", rsp_valid, 0);
    halted = 1'b1;
    waitResp(10, cyc);
    checkOutput("step_latency", cyc, 1);
    checkOutput("step_err", rsp_err, 0);
    finishResp();

    // STEP on a running core fails and leaves halt_req alone.
    applyStimulus(OP_RESUME, 12'd0, 32'd0);
    finishResp();
    halted = 1'b0;
    applyStimulus(OP_STEP, 12'd0, 32'd0);
    checkOutput("step_run_err", {rsp_valid, rsp_err}, 2'b11);
    checkOutput("step_run_halt_req", halt_req, 0);
    finishResp();

    // ebreak while running auto-halts and shows in STATUS.
    brk = 1'b1;
    tick();
    brk = 1'b0;
    checkOutput("brk_halt_req", halt_req, 1);
    halted = 1'b1;
    tick();
    applyStimulus(OP_STATUS, 12'd0, 32'd0);
    checkOutput("brk_status", rsp_data, 32'h3);
    finishResp();

    // RESUME clears the break flag.
    applyStimulus(OP_RESUME, 12'd0, 32'd0);
    checkOutput("resume2_halt_req", halt_req, 0);
    finishResp();
    halted = 1'b0;
    tick();
    applyStimulus(OP_STATUS, 12'd0, 32'd0);
    checkOutput("resume2_status", rsp_data, 32'h0);
    finishResp();

    // brk coincident with RESUME acceptance: brk wins.
    brk = 1'b1;
    applyStimulus(OP_RESUME, 12'd0, 32'd0);
    brk = 1'b0;
    checkOutput("brk_vs_resume", halt_req, 1);
    finishResp();
    halted = 1'b1;

    // Response held off for ten cycles while a new command is offered.
    applyStimulus(OP_STATUS, 12'd0, 32'd0);
    cmd_valid = 1'b1;
    cmd_op = OP_HALT;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("stall_valid", rsp_valid, 1);
      checkOutput("stall_data", rsp_data, 32'h3);
      checkOutput("stall_no_accept", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    finishResp();
    tick();
    checkOutput("stall_no_extra_rsp", rsp_valid, 0);

    // Reset while in ACCESS aborts the command.
    applyStimulus(OP_RD_GPR, 12'd3, 32'd0);
    checkOutput("abort_ren", gpr_ren, 1);
    reset = 1'b0;
    #1;
    checkOutput("abort_ren_cleared", gpr_ren, 0);
    checkOutput("abort_halt_req", halt_req, 0);
    checkOutput("abort_cmd_ready", cmd_ready, 1);
    checkOutput("abort_rsp", {rsp_valid, rsp_err}, 2'b00);
    checkOutput("abort_rsp_data", rsp_data, 32'h0);
    reset = 1'b1;
    tick();
    tick();
    checkOutput("abort_no_rsp", rsp_valid, 0);
    applyStimulus(OP_STATUS, 12'd0, 32'd0);
    checkOutput("abort_status", rsp_data, 32'h1);
    finishResp();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
